// File: rtl/rf_pkg.sv
// Shared register-file types: architectural register count/address width and the
// {addr, data} write-back entry used by the write buffer and the load/store unit.
package rf_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;
  localparam int RF_N      = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [RF_N-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match priority select: entries are presented oldest-first (index 0), and the
// highest-index valid entry whose address equals the key wins. Purely combinational.
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [AW-1:0]             key_i,
  input  logic [DEPTH-1:0]          vld_i,
  input  logic [DEPTH-1:0][AW-1:0]  addr_i,
  input  logic [DEPTH-1:0][DW-1:0]  data_i,
  output logic                      hit_o,
  output logic [DW-1:0]             data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_i[i] && (addr_i[i] == key_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/wb_write_buffer.sv
// Write-back queue in front of the register file: accepts results one per cycle, retires them
// in order one per cycle (min 1-cycle residency), and exposes pending/forwarding lookups for decode.
module wb_write_buffer
  import rf_pkg::*;
#(
  parameter int n     = RF_N,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_AW-1:0]    in_addr,
  input  logic [n-1:0]         in_data,
  input  logic                 flush,
  input  logic                 wr_stall,
  output logic                 regWrite,
  output logic [REG_AW-1:0]    writeAddr,
  output logic [n-1:0]         writeData,
  input  logic [REG_AW-1:0]    fwd_addr,
  output logic                 fwd_hit,
  output logic [n-1:0]         fwd_data,
  output logic [REG_COUNT-1:0] pending,
  output logic [PW:0]          count
);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             push, pop, nonempty;

  assign nonempty = (count_q != '0);
  // Full blocks intake even when the head retires this cycle: no same-cycle refill.
  assign in_ready = (count_q < (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready && !flush && (in_addr != '0);
  assign pop      = nonempty && !wr_stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q].addr <= in_addr;
      mem_q[tail_q].data <= in_data;
    end
  end

  assign regWrite  = pop;
  assign writeAddr = nonempty ? mem_q[head_q].addr : '0;
  assign writeData = nonempty ? mem_q[head_q].data : '0;
  assign count     = count_q;

  // Age-ordered view of the ring: slot k is the k-th oldest live entry.
  logic [DEPTH-1:0]             ord_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ord_addr;
  logic [DEPTH-1:0][n-1:0]      ord_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    logic [PW-1:0] idx;
    assign idx         = head_q + PW'(k);
    assign ord_vld[k]  = ((PW+1)'(k) < count_q);
    assign ord_addr[k] = mem_q[idx].addr;
    assign ord_data[k] = mem_q[idx].data;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i]) pending[ord_addr[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  logic         match_hit;
  logic [n-1:0] match_data;

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (REG_AW),
    .DW    (n)
  ) u_fwd_match (
    .key_i  (fwd_addr),
    .vld_i  (ord_vld),
    .addr_i (ord_addr),
    .data_i (ord_data),
    .hit_o  (match_hit),
    .data_o (match_data)
  );

  assign fwd_hit  = match_hit && (fwd_addr != '0);
  assign fwd_data = fwd_hit ? match_data : '0;

endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer: a queue-level reference model predicts every
// retired write and the per-cycle status outputs; a negedge monitor compares.
module tb_wb_write_buffer;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_addr = '0;
  logic [N-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          wr_stall = 1'b0;
  logic          regWrite;
  logic [4:0]    writeAddr;
  logic [N-1:0]  writeData;
  logic [4:0]    fwd_addr = '0;
  logic          fwd_hit;
  logic [N-1:0]  fwd_data;
  logic [31:0]   pending;
  logic [PW:0]   count;

  wb_write_buffer #(.n(N), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .flush     (flush),
    .wr_stall  (wr_stall),
    .regWrite  (regWrite),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .pending   (pending),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   a;
    logic [N-1:0] d;
  } ent_t;

  ent_t mdl[$];    // entries the buffer should currently hold, oldest first
  ent_t exp_q[$];  // scoreboard of register-file writes still expected, in order
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0]  pend;
    logic         hit;
    logic [N-1:0] fd;
    logic         rw_exp;
    ent_t         e;
    pend = '0;
    hit  = 1'b0;
    fd   = '0;
    foreach (mdl[i]) begin
      pend[mdl[i].a] = 1'b1;
      if (fwd_addr != 0 && mdl[i].a == fwd_addr) begin
        hit = 1'b1;
        fd  = mdl[i].d;
      end
    end
    rw_exp = (mdl.size() > 0) && !wr_stall && !flush;
    chk("count", 64'(count), 64'(mdl.size()));
    chk("in_ready", 64'(in_ready), 64'(mdl.size() < DEPTH));
    chk("regWrite", 64'(regWrite), 64'(rw_exp));
    if (mdl.size() > 0) begin
      chk("head_addr", 64'(writeAddr), 64'(mdl[0].a));
      chk("head_data", 64'(writeData), 64'(mdl[0].d));
    end else begin
      chk("idle_addr", 64'(writeAddr), 64'(0));
      chk("idle_data", 64'(writeData), 64'(0));
    end
    chk("pending", 64'(pending), 64'(pend));
    chk("fwd_hit", 64'(fwd_hit), 64'(hit));
    chk("fwd_data", 64'(fwd_data), 64'(fd));
    if (regWrite) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_write: got write r%0d=%0h, expected none", writeAddr, writeData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_seq_addr", 64'(writeAddr), 64'(e.a));
        chk("wr_seq_data", 64'(writeData), 64'(e.d));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) check_outputs();
  end

  // Applies the edge's effect to the model using the inputs held through that edge.
  task automatic model_edge();
    int   sz;
    logic pu, po;
    ent_t e;
    if (!rst) return;
    sz = mdl.size();
    pu = in_valid && (sz < DEPTH) && !flush && (in_addr != 0);
    po = (sz > 0) && !wr_stall && !flush;
    if (flush) begin
      mdl.delete();
      exp_q.delete();
    end else begin
      if (po) void'(mdl.pop_front());
      if (pu) begin
        e.a = in_addr;
        e.d = in_data;
        mdl.push_back(e);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [N-1:0] d,
                      input logic fl, input logic st, input logic [4:0] fa);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    flush    = fl;
    wr_stall = st;
    fwd_addr = fa;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single write with latency check on the following cycle.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd5);
    step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd5);
    idle(2);

    // Fill under stall; fifth push must bounce off the full buffer.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 256), 1'b0, 1'b1, 5'(i));
    step(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd9);
    chk("full_count", 64'(count), 64'(4));
    idle(6);

    // Youngest-match forwarding.
    step(1'b1, 5'd7, 32'h11, 1'b0, 1'b1, 5'd7);
    step(1'b1, 5'd7, 32'h22, 1'b0, 1'b1, 5'd7);
    chk("fwd_youngest", 64'(fwd_data), 64'(32'h22));
    step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd0);
    idle(4);

    // Write to x0 is accepted and discarded.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0);
    chk("x0_count", 64'(count), 64'(0));
    idle(2);

    // Flush with an incoming entry.
    for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 10), 32'(i), 1'b0, 1'b1, 5'd12);
    step(1'b1, 5'd20, 32'hAB, 1'b1, 1'b0, 5'd20);
    chk("flush_count", 64'(count), 64'(0));
    idle(2);

    // Asynchronous reset mid-run with three entries queued.
    for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 3), 32'(i + 100), 1'b0, 1'b1, 5'd4);
    in_valid = 1'b0;
    wr_stall = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_regWrite", 64'(regWrite), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    mdl.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    idle(2);

    // Randomized traffic with flushes, stalls and frequent address reuse.
    for (int i = 0; i < 3000; i++) begin
      logic       v, fl, st;
      logic [4:0] a, fa;
      v  = ($urandom_range(9) < 7);
      a  = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      fl = ($urandom_range(31) == 0);
      st = ($urandom_range(3) == 0);
      fa = 5'($urandom_range(7));
      step(v, a, $urandom, fl, st, fa);
    end

    idle(DEPTH + 2);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
